m2v_side1_seq: RTL and testbench

M2V_SIDE1_SEQ -- requirements
Module: m2vside1

---
 rtl/m2v_side1_seq.sv | 189 ++++++++++++++++++
 tb/tb_m2v_side1_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m2v_side1_seq.sv
// Stage-1 macroblock sequencer.
// Holds the current macroblock header (CUR) that drives the stage-2 block
// container, plus a one-entry lookahead buffer (NXT) so the next header can
// be taken while the current one is still being walked block by block.
// Each block_start pulse advances through the six 8x8 blocks (0..5); after
// block 5 the sequencer either promotes NXT, bypasses a fresh header straight
// into CUR, or drops back to IDLE.
//
// Header handshake (mb_valid / mb_ready):
//   A header is transferred on a rising edge where mb_valid & mb_ready are
//   both high. mb_ready is purely a function of registered state
//   (~NXT_full), so it never depends on mb_valid in the same cycle. The
//   producer must hold the header fields stable while mb_valid is high and
//   mb_ready is low; a header is taken exactly once.
module m2v_side1_seq #(
    parameter int MVH_WIDTH = 16,
    parameter int MVV_WIDTH = 15,
    parameter int MBX_WIDTH = 6,
    parameter int MBY_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    // header input handshake
    input  logic                 mb_valid,
    output logic                 mb_ready,
    input  logic [MVH_WIDTH-1:0] mb_mv_h,
    input  logic [MVV_WIDTH-1:0] mb_mv_v,
    input  logic [MBX_WIDTH-1:0] mb_x,
    input  logic [MBY_WIDTH-1:0] mb_y,
    input  logic                 mb_intra,
    input  logic [5:0]           mb_cbp,
    // stage-2 consumption strobe
    input  logic                 block_start,
    // registered stage-1 outputs
    output logic [MVH_WIDTH-1:0] s1_mv_h,
    output logic [MVV_WIDTH-1:0] s1_mv_v,
    output logic [MBX_WIDTH-1:0] s1_mb_x,
    output logic [MBY_WIDTH-1:0] s1_mb_y,
    output logic                 s1_mb_intra,
    output logic [2:0]           s1_block,
    output logic                 s1_coded,
    output logic                 s1_enable,
    output logic                 mb_done,
    // debug view of the sequencer state (0 = IDLE, 1 = ACTIVE)
    output logic                 dbg_state
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // One macroblock header as stored in CUR and NXT.
    typedef struct packed {
        logic [MVH_WIDTH-1:0] mv_h;
        logic [MVV_WIDTH-1:0] mv_v;
        logic [MBX_WIDTH-1:0] x;
        logic [MBY_WIDTH-1:0] y;
        logic                 intra;
        logic [5:0]           cbp;
    } hdr_t;

    localparam logic [2:0] LAST_BLOCK = 3'd5;

    state_e     state_q, state_d;
    hdr_t       cur_q, cur_d;
    hdr_t       nxt_q, nxt_d;
    logic       nxt_full_q, nxt_full_d;
    logic [2:0] block_q, block_d;
    logic       coded_q, coded_d;
    logic       done_q, done_d;

    hdr_t       in_hdr;
    logic       accept;
    logic       last_block;
    logic       block_adv;
    logic       block_end;

    // Gather the incoming header fields into one record.
    always_comb begin
        in_hdr       = '0;
        in_hdr.mv_h  = mb_mv_h;
        in_hdr.mv_v  = mb_mv_v;
        in_hdr.x     = mb_x;
        in_hdr.y     = mb_y;
        in_hdr.intra = mb_intra;
        in_hdr.cbp   = mb_cbp;
    end

    assign mb_ready   = ~nxt_full_q;
    assign accept     = mb_valid & mb_ready;
    assign last_block = (block_q == LAST_BLOCK);
    assign block_adv  = (state_q == ACTIVE) & block_start & ~last_block;
    assign block_end  = (state_q == ACTIVE) & block_start & last_block;

    // Next-state logic: header intake, block walk and end-of-macroblock handoff.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        nxt_d      = nxt_q;
        nxt_full_d = nxt_full_q;
        block_d    = block_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // block_start is meaningless without a header and is dropped.
                if (accept) begin
                    cur_d   = in_hdr;
                    block_d = 3'd0;
                    state_d = ACTIVE;
                end
            end

            ACTIVE: begin
                if (block_adv) begin
                    block_d = block_q + 3'd1;
                end

                if (block_end) begin
                    done_d = 1'b1;
                    if (nxt_full_q) begin
                        // Promote the buffered header; no gap on s1_enable.
                        cur_d      = nxt_q;
                        block_d    = 3'd0;
                        nxt_full_d = 1'b0;
                        // mb_ready is low whenever NXT is full, so this refill
                        // cannot fire today; it keeps NXT correct should
                        // mb_ready ever be allowed to look ahead.
                        if (accept) begin
                            nxt_d      = in_hdr;
                            nxt_full_d = 1'b1;
                        end
                    end else if (accept) begin
                        // NXT empty: the arriving header goes straight to CUR.
                        cur_d   = in_hdr;
                        block_d = 3'd0;
                    end else begin
                        // Nothing queued: park with the old header visible.
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    nxt_d      = in_hdr;
                    nxt_full_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Block 0 is cbp bit 5, block 5 is cbp bit 0; intra codes every block.
        coded_d = cur_d.intra | cur_d.cbp[LAST_BLOCK - block_d];
    end

    // State and output registers; reset empties both header slots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            nxt_q      <= '0;
            nxt_full_q <= 1'b0;
            block_q    <= 3'd0;
            coded_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            nxt_full_q <= nxt_full_d;
            block_q    <= block_d;
            coded_q    <= coded_d;
            done_q     <= done_d;
        end
    end

    assign s1_mv_h     = cur_q.mv_h;
    assign s1_mv_v     = cur_q.mv_v;
    assign s1_mb_x     = cur_q.x;
    assign s1_mb_y     = cur_q.y;
    assign s1_mb_intra = cur_q.intra;
    assign s1_block    = block_q;
    assign s1_coded    = coded_q;
    assign s1_enable   = (state_q == ACTIVE);
    assign mb_done     = done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_m2v_side1_seq.sv
// Testbench for m2v_side1_seq: directed headers and block_start sequences,
// expected blocks and mb_done pulses queued at issue time and checked by
// independent monitors.
module tb_m2v_side1_seq;

    localparam int MVH = 16;
    localparam int MVV = 15;
    localparam int MBX = 6;
    localparam int MBY = 5;
    localparam int EW  = MBX + MBY + MVH + MVV + 1 + 3 + 1;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           mb_valid = 1'b0;
    logic           mb_ready;
    logic [MVH-1:0] mb_mv_h = '0;
    logic [MVV-1:0] mb_mv_v = '0;
    logic [MBX-1:0] mb_x = '0;
    logic [MBY-1:0] mb_y = '0;
    logic           mb_intra = 1'b0;
    logic [5:0]     mb_cbp = '0;
    logic           block_start = 1'b0;
    logic [MVH-1:0] s1_mv_h;
    logic [MVV-1:0] s1_mv_v;
    logic [MBX-1:0] s1_mb_x;
    logic [MBY-1:0] s1_mb_y;
    logic           s1_mb_intra;
    logic [2:0]     s1_block;
    logic           s1_coded;
    logic           s1_enable;
    logic           mb_done;
    logic           dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [EW-1:0] exp_q[$];
    int            done_q[$];

    m2v_side1_seq #(
        .MVH_WIDTH(MVH),
        .MVV_WIDTH(MVV),
        .MBX_WIDTH(MBX),
        .MBY_WIDTH(MBY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mb_valid   (mb_valid),
        .mb_ready   (mb_ready),
        .mb_mv_h    (mb_mv_h),
        .mb_mv_v    (mb_mv_v),
        .mb_x       (mb_x),
        .mb_y       (mb_y),
        .mb_intra   (mb_intra),
        .mb_cbp     (mb_cbp),
        .block_start(block_start),
        .s1_mv_h    (s1_mv_h),
        .s1_mv_v    (s1_mv_v),
        .s1_mb_x    (s1_mb_x),
        .s1_mb_y    (s1_mb_y),
        .s1_mb_intra(s1_mb_intra),
        .s1_block   (s1_block),
        .s1_coded   (s1_coded),
        .s1_enable  (s1_enable),
        .mb_done    (mb_done),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic set_hdr(input logic [MBX-1:0] x, input logic [MBY-1:0] y,
                           input logic [MVH-1:0] h, input logic [MVV-1:0] v,
                           input logic intra, input logic [5:0] cbp);
        mb_x     = x;
        mb_y     = y;
        mb_mv_h  = h;
        mb_mv_v  = v;
        mb_intra = intra;
        mb_cbp   = cbp;
    endtask

    // pat: hand-computed s1_coded for blocks 0..5, block 0 in the MSB.
    task automatic push_hdr(input logic [5:0] pat);
        for (int b = 0; b < 6; b++) begin
            exp_q.push_back({mb_x, mb_y, mb_mv_h, mb_mv_v, mb_intra, 3'(b), pat[5-b]});
        end
    endtask

    // One clock of stimulus; inputs change #1 after the rising edge.
    task automatic cycle(input logic bs, input logic v, input logic [5:0] pat, output logic acc);
        block_start = bs;
        mb_valid    = v;
        acc         = v & mb_ready;
        if (acc) push_hdr(pat);
        @(posedge clk);
        #1;
        block_start = 1'b0;
        mb_valid    = 1'b0;
    endtask

    // n back-to-back block_start pulses; the last one ends the macroblock if fin.
    task automatic pulses(input int n, input bit fin);
        logic acc;
        for (int i = 0; i < n; i++) begin
            if (fin && i == n - 1) done_q.push_back(1);
            cycle(1'b1, 1'b0, 6'd0, acc);
        end
    endtask

    // ---------------- monitors ----------------
    logic bs_edge = 1'b0;
    logic en_prev = 1'b0;

    always @(posedge clk) bs_edge <= block_start;

    // A new block is presented when s1_enable rises or after a consumed pulse.
    always @(negedge clk) begin
        logic [EW-1:0] act;
        logic [EW-1:0] exp;
        if (reset) begin
            en_prev = 1'b0;
        end else begin
            if (s1_enable && (!en_prev || bs_edge)) begin
                act = {s1_mb_x, s1_mb_y, s1_mv_h, s1_mv_v, s1_mb_intra, s1_block, s1_coded};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL blk_unexpected: got %0h required none", act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        n_errors++;
                        $display("FAIL blk_compare: got %0h required %0h", act, exp);
                    end
                end
            end
            if (mb_done) begin
                n_checks++;
                if (done_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL mb_done_unexpected: got 1 required 0");
                end else begin
                    void'(done_q.pop_front());
                end
            end
            en_prev = s1_enable;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic acc;
        int   acc_cnt;

        // reset state (checked asynchronously, before any clock edge)
        #1 reset = 1'b1;
        #2;
        chk("rst_enable", s1_enable, 0);
        chk("rst_block", s1_block, 0);
        chk("rst_coded", s1_coded, 0);
        chk("rst_done", mb_done, 0);
        chk("rst_ready", mb_ready, 1);
        chk("rst_state", dbg_state, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // single non-intra header, gapped pulses, back to IDLE
        set_hdr(6'd3, 5'd2, 16'h1234, 15'h0567, 1'b0, 6'b101001);
        cycle(1'b0, 1'b1, 6'b101001, acc);
        chk("a_accept", acc, 1);
        chk("a_enable_lat1", s1_enable, 1);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) done_q.push_back(1);
            cycle(1'b1, 1'b0, 6'd0, acc);
            cycle(1'b0, 1'b0, 6'd0, acc);
        end
        chk("a_enable_off", s1_enable, 0);

        // intra header with cbp=0: all blocks coded
        set_hdr(6'd1, 5'd1, 16'hFFFF, 15'h7FFF, 1'b1, 6'b000000);
        cycle(1'b0, 1'b1, 6'b111111, acc);
        pulses(6, 1'b1);
        chk("i_enable_off", s1_enable, 0);

        // block_start in IDLE is ignored
        pulses(3, 1'b0);
        chk("idle_enable", s1_enable, 0);
        chk("idle_mb_x_held", s1_mb_x, 1);
        chk("idle_intra_held", s1_mb_intra, 1);

        // B into CUR, C into NXT, D held off until B finishes
        set_hdr(6'd5, 5'd4, 16'h00A5, 15'h1111, 1'b0, 6'b110000);
        cycle(1'b0, 1'b1, 6'b110000, acc);
        set_hdr(6'd6, 5'd7, 16'h8001, 15'h4002, 1'b0, 6'b000011);
        cycle(1'b0, 1'b1, 6'b000011, acc);
        chk("c_accept", acc, 1);
        chk("nxt_full_ready", mb_ready, 0);
        set_hdr(6'd7, 5'd8, 16'h0F0F, 15'h2222, 1'b0, 6'b011110);
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) done_q.push_back(1);
            cycle(1'b1, 1'b1, 6'b011110, acc);
            acc_cnt += int'(acc);
        end
        chk("d_held_off", acc_cnt, 0);
        chk("xfer_enable", s1_enable, 1);
        chk("xfer_block", s1_block, 0);
        chk("xfer_mb_x", s1_mb_x, 6);
        chk("xfer_ready", mb_ready, 1);
        cycle(1'b0, 1'b1, 6'b011110, acc);
        chk("d_accept", acc, 1);
        pulses(6, 1'b1);
        chk("d_in_cur", s1_mb_x, 7);
        pulses(6, 1'b1);
        chk("d_enable_off", s1_enable, 0);

        // bypass: header accepted on the edge of the sixth pulse
        set_hdr(6'd9, 5'd3, 16'h5555, 15'h2AAA, 1'b0, 6'b000001);
        cycle(1'b0, 1'b1, 6'b000001, acc);
        pulses(5, 1'b0);
        set_hdr(6'd10, 5'd11, 16'hABCD, 15'h0123, 1'b0, 6'b100010);
        done_q.push_back(1);
        cycle(1'b1, 1'b1, 6'b100010, acc);
        chk("f_bypass_accept", acc, 1);
        chk("f_enable", s1_enable, 1);
        chk("f_block", s1_block, 0);
        chk("f_mb_x", s1_mb_x, 10);
        pulses(6, 1'b1);

        // reset mid-macroblock at block 3 with NXT full
        set_hdr(6'd12, 5'd12, 16'h1111, 15'h3333, 1'b0, 6'b111000);
        cycle(1'b0, 1'b1, 6'b111000, acc);
        set_hdr(6'd13, 5'd13, 16'h2222, 15'h4444, 1'b1, 6'b000000);
        cycle(1'b0, 1'b1, 6'b111111, acc);
        pulses(3, 1'b0);
        chk("g_block3", s1_block, 3);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_enable", s1_enable, 0);
        chk("mid_rst_block", s1_block, 0);
        chk("mid_rst_coded", s1_coded, 0);
        chk("mid_rst_mb_x", s1_mb_x, 0);
        chk("mid_rst_mv_h", s1_mv_h, 0);
        chk("mid_rst_ready", mb_ready, 1);
        chk("mid_rst_done", mb_done, 0);
        exp_q.delete();
        done_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        set_hdr(6'd63, 5'd31, 16'h8000, 15'h4000, 1'b0, 6'b010101);
        cycle(1'b0, 1'b1, 6'b010101, acc);
        chk("post_rst_accept", acc, 1);
        chk("post_rst_block", s1_block, 0);
        chk("post_rst_enable", s1_enable, 1);
        pulses(6, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
